// File: rtl/refresh_if.sv
// Refresh handshake between refresh_timer and the RAM sequencer.
// REFRESH_OVERRUN_EN adds the sticky overrun flag and its clear strobe.
interface refresh_if #(
  parameter int MAX_PENDING = 7
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          ref_ack;
  logic          ref_req;
  logic          ref_urgent;
  logic          init_done;
  logic [PW-1:0] pending;
`ifdef REFRESH_OVERRUN_EN
  logic          overrun;
  logic          ov_clr;

  modport master (
    input  ref_ack, ov_clr,
    output ref_req, ref_urgent, init_done, pending, overrun
  );
  modport slave (
    output ref_ack, ov_clr,
    input  ref_req, ref_urgent, init_done, pending, overrun
  );
`else
  modport master (
    input  ref_ack,
    output ref_req, ref_urgent, init_done, pending
  );
  modport slave (
    output ref_ack,
    input  ref_req, ref_urgent, init_done, pending
  );
`endif
endinterface

// File: rtl/refresh_timer.sv
// DRAM refresh scheduler: prescaled refresh debt, request/urgent outputs and power-up refresh sequence.
// Optional feature macro: REFRESH_OVERRUN_EN (sticky overrun flag when debt saturates).
module refresh_timer #(
  parameter int REF_PERIOD    = 250,
  parameter int URGENT_THRESH = 2,
  parameter int MAX_PENDING   = 7,
  parameter int INIT_REFS     = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  refresh_if.master bus
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int CW = $clog2(REF_PERIOD);
  localparam int IW = $clog2(INIT_REFS + 1);

  localparam logic [CW-1:0] PRESC_LAST = CW'(REF_PERIOD - 1);
  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_REFS - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);
  localparam logic [PW-1:0] URG_LVL    = PW'(URGENT_THRESH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [IW-1:0] init_q, init_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          ack_q;
  logic          ack_ev;
  logic          tick;
  logic          req_q, req_d;
  logic          urg_q, urg_d;
  logic          done_q, done_d;

  // A held RefAck counts once: only its rising edge retires debt.
  assign ack_ev = bus.ref_ack & ~ack_q;
  assign tick   = (presc_q == PRESC_LAST);

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + CW'(1);
    init_d    = init_q;
    pending_d = pending_q;
    req_d     = 1'b1;
    urg_d     = 1'b1;
    done_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (ack_ev) begin
          init_d = init_q + IW'(1);
          if (init_q == INIT_LAST) begin
            state_d   = ST_RUN;
            presc_d   = '0;
            pending_d = '0;
          end
        end
      end
      ST_RUN: begin
        req_d  = (pending_q != '0);
        urg_d  = (pending_q >= URG_LVL);
        done_d = 1'b1;
        if (tick && !ack_ev && (pending_q != PEND_MAX))
          pending_d = pending_q + PW'(1);
        else if (ack_ev && !tick && (pending_q != '0))
          pending_d = pending_q - PW'(1);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      presc_q   <= '0;
      init_q    <= '0;
      pending_q <= '0;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      urg_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      init_q    <= init_d;
      pending_q <= pending_d;
      ack_q     <= bus.ref_ack;
      req_q     <= req_d;
      urg_q     <= urg_d;
      done_q    <= done_d;
    end
  end

  assign bus.ref_req    = req_q;
  assign bus.ref_urgent = urg_q;
  assign bus.init_done  = done_q;
  assign bus.pending    = pending_q;

`ifdef REFRESH_OVERRUN_EN
  logic overrun_q;
  logic ov_set;

  // A tick that cannot be recorded because debt is already saturated; set beats clear.
  assign ov_set = (state_q == ST_RUN) && tick && !ack_ev && (pending_q == PEND_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_q <= 1'b0;
    else if (ov_set)
      overrun_q <= 1'b1;
    else if (bus.ov_clr)
      overrun_q <= 1'b0;
  end

  assign bus.overrun = overrun_q;
`endif
endmodule
